// File: rtl/bin_a_bcd_if.sv
// bin_a_bcd_if: start/busy/done handshake and data bus of the binary-to-BCD converter
// Inicio/Entrada driven by the upstream sequencer (master).
// Ocupado/Listo/BCD driven by the converter (slave).
interface bin_a_bcd_if #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
);
    logic                   Inicio;
    logic [ANCHO-1:0]       Entrada;
    logic                   Ocupado;
    logic                   Listo;
    logic [4*DIGITOS-1:0]   BCD;
    modport master (output Inicio, Entrada, input Ocupado, Listo, BCD);
    modport slave  (input Inicio, Entrada, output Ocupado, Listo, BCD);
endinterface

// File: rtl/bin_a_bcd_secuencial.sv
// bin_a_bcd_secuencial: sequential shift-and-add-3 binary-to-BCD converter, one shift per clock
// clk/rst: single clock, synchronous active-high reset.
// conv: Inicio (start), Entrada (binary in), Ocupado (busy), Listo (done pulse), BCD (digits, k=0 units).
module bin_a_bcd_secuencial #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin_a_bcd_if.slave    conv
);
    localparam int CW = $clog2(ANCHO + 1);
    localparam int BW = 4 * DIGITOS;
    typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_t;
    estado_t           estado_q, estado_d;
    logic [ANCHO-1:0]  bin_q, bin_d;
    logic [BW-1:0]     scr_q, scr_d, ajustado;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              listo_q, listo_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= REPOSO;
            bin_q    <= '0;
            scr_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            listo_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            bin_q    <= bin_d;
            scr_q    <= scr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            listo_q  <= listo_d;
        end
    end
    always_comb begin
        estado_d = estado_q;
        bin_d    = bin_q;
        scr_d    = scr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        listo_d  = 1'b0;
        ajustado = scr_q;
        for (int k = 0; k < DIGITOS; k++)
            ajustado[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
        case (estado_q)
            REPOSO: if (conv.Inicio) begin
                bin_d    = conv.Entrada;
                scr_d    = '0;
                cnt_d    = CW'(ANCHO);
                estado_d = DESPLAZA;
            end
            DESPLAZA: begin
                // adjust digits first, then the binary MSB shifts into scratch bit 0
                {scr_d, bin_d} = {ajustado, bin_q} << 1;
                cnt_d          = cnt_q - CW'(1);
                estado_d       = (cnt_q == CW'(1)) ? FIN : DESPLAZA;
            end
            FIN: begin
                bcd_d    = scr_q;
                listo_d  = 1'b1;
                estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end
    assign conv.Ocupado = (estado_q != REPOSO);
    assign conv.Listo   = listo_q;
    assign conv.BCD     = bcd_q;
endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// tb_bin_a_bcd_secuencial: directed self-checking bench for bin_a_bcd_secuencial
module tb_bin_a_bcd_secuencial;
    logic clk;
    logic rst;
    int   vectors;
    int   errores;
    bin_a_bcd_if #(.ANCHO(8), .DIGITOS(3)) bus ();
    bin_a_bcd_secuencial #(.ANCHO(8), .DIGITOS(3)) dut (.clk(clk), .rst(rst), .conv(bus));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [11:0] a_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    task automatic arranca(input logic [7:0] v);
        bus.Inicio  = 1'b1;
        bus.Entrada = v;
        tick();
        bus.Inicio  = 1'b0;
    endtask
    task automatic espera_listo(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.Listo) begin
                n = i;
                break;
            end
            tick();
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.Inicio  = 1'b0;
        bus.Entrada = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (bus.Ocupado !== 1'b0 || bus.Listo !== 1'b0 || bus.BCD !== 12'h000) begin
                errores++;
                $display("FAIL reset_idle cycle %0d got ocupado=%b listo=%b bcd=%h exp 0 0 000", i, bus.Ocupado, bus.Listo, bus.BCD);
            end
            tick();
        end
    endtask
    task automatic test_225();
        int ocup = 0, pulsos = 0, en = -1;
        logic [11:0] res = '0;
        arranca(8'd225);
        for (int i = 0; i <= 14; i++) begin
            if (bus.Ocupado) ocup++;
            if (bus.Listo) begin
                pulsos++;
                en  = i;
                res = bus.BCD;
            end
            tick();
        end
        vectors++;
        if (ocup !== 9) begin errores++; $display("FAIL t225_ocupado got %0d cycles exp 9", ocup); end
        vectors++;
        if (pulsos !== 1) begin errores++; $display("FAIL t225_pulsos got %0d exp 1", pulsos); end
        vectors++;
        if (en !== 9) begin errores++; $display("FAIL t225_latencia got %0d exp 9", en); end
        vectors++;
        if (res !== 12'h225) begin errores++; $display("FAIL t225_bcd got %h exp 225", res); end
    endtask
    task automatic test_sweep();
        int n;
        logic [7:0]  tv [6] = '{8'd255, 8'd99, 8'd63, 8'd0, 8'd100, 8'd196};
        logic [11:0] te [6] = '{12'h255, 12'h099, 12'h063, 12'h000, 12'h100, 12'h196};
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                arranca(8'(x * y));
                espera_listo(n);
                vectors++;
                if (n !== 9 || bus.BCD !== a_bcd(x * y)) begin
                    errores++;
                    $display("FAIL sweep %0d*%0d got bcd=%h lat=%0d exp bcd=%h lat=9", x, y, bus.BCD, n, a_bcd(x * y));
                end
            end
        for (int i = 0; i < 6; i++) begin
            arranca(tv[i]);
            espera_listo(n);
            vectors++;
            if (bus.BCD !== te[i]) begin
                errores++;
                $display("FAIL directo %0d got %h exp %h", tv[i], bus.BCD, te[i]);
            end
        end
        tick();
    endtask
    task automatic test_busy();
        int pulsos = 0, en = -1;
        logic [11:0] res = '0;
        arranca(8'd100);
        for (int i = 0; i <= 22; i++) begin
            if (bus.Listo) begin
                pulsos++;
                en  = i;
                res = bus.BCD;
            end
            if (i == 2) begin
                bus.Inicio  = 1'b1;
                bus.Entrada = 8'd42;
            end
            if (i == 3) begin
                bus.Inicio  = 1'b0;
                bus.Entrada = 8'd77;
            end
            tick();
        end
        vectors++;
        if (pulsos !== 1) begin errores++; $display("FAIL busy_pulsos got %0d exp 1", pulsos); end
        vectors++;
        if (en !== 9) begin errores++; $display("FAIL busy_latencia got %0d exp 9", en); end
        vectors++;
        if (res !== 12'h100) begin errores++; $display("FAIL busy_bcd got %h exp 100", res); end
        vectors++;
        if (bus.BCD !== 12'h100) begin errores++; $display("FAIL busy_hold got %h exp 100", bus.BCD); end
    endtask
    task automatic test_back_to_back();
        int pulsos = 0;
        int t [2] = '{-1, -1};
        logic [11:0] r [2] = '{12'h0, 12'h0};
        bus.Inicio  = 1'b1;
        bus.Entrada = 8'd56;
        tick();
        bus.Entrada = 8'd144;
        for (int i = 0; i <= 25; i++) begin
            if (bus.Listo) begin
                if (pulsos < 2) begin
                    t[pulsos] = i;
                    r[pulsos] = bus.BCD;
                end
                pulsos++;
            end
            if (i == 10) bus.Entrada = 8'd7;
            if (i == 19) bus.Inicio = 1'b0;
            tick();
        end
        vectors++;
        if (pulsos !== 2) begin errores++; $display("FAIL b2b_pulsos got %0d exp 2", pulsos); end
        vectors++;
        if (t[0] !== 9 || t[1] !== 19) begin errores++; $display("FAIL b2b_tiempos got %0d,%0d exp 9,19", t[0], t[1]); end
        vectors++;
        if (r[0] !== 12'h056) begin errores++; $display("FAIL b2b_bcd0 got %h exp 056", r[0]); end
        vectors++;
        if (r[1] !== 12'h144) begin errores++; $display("FAIL b2b_bcd1 got %h exp 144", r[1]); end
    endtask
    task automatic test_reset_mid();
        int pulsos = 0, n;
        arranca(8'd200);
        for (int i = 0; i < 4; i++) begin
            if (bus.Listo) pulsos++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.Ocupado !== 1'b0 || bus.Listo !== 1'b0 || bus.BCD !== 12'h000) begin
            errores++;
            $display("FAIL rstmid_estado got ocupado=%b listo=%b bcd=%h exp 0 0 000", bus.Ocupado, bus.Listo, bus.BCD);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.Listo) pulsos++;
            tick();
        end
        vectors++;
        if (pulsos !== 0) begin errores++; $display("FAIL rstmid_pulsos got %0d exp 0", pulsos); end
        arranca(8'd200);
        espera_listo(n);
        vectors++;
        if (n !== 9 || bus.BCD !== 12'h200) begin
            errores++;
            $display("FAIL rstmid_reconv got bcd=%h lat=%0d exp 200 lat=9", bus.BCD, n);
        end
    endtask
    initial begin
        vectors     = 0;
        errores     = 0;
        rst         = 1'b1;
        bus.Inicio  = 1'b0;
        bus.Entrada = 8'd0;
        test_reset();
        test_225();
        test_sweep();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errores);
        $finish;
    end
endmodule
